// File: rtl/spi_packet_master_rx.sv
// SPI mode-0 master that clocks in a 16-byte sensor packet and unpacks it
// into registered quaternion/gyro fields once the 0xAA header checks out.
module spi_packet_master_rx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               cs_n,
  output logic               sck,
  output logic               sdo,
  input  logic               sdi,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               quat_valid,
  output logic               gyro_valid,
  output logic               pkt_valid,
  output logic               hdr_err,
  output logic [15:0]        good_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LOW,
    SCK_HIGH,
    HOLD
  } state_t;

  localparam logic [7:0] HEADER    = 8'hAA;
  localparam logic [7:0] PKT_BITS  = 8'd128;
  localparam logic [7:0] DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LD  = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LD   = 8'(CS_HOLD - 1);

  state_t               state_q, state_d;
  logic [7:0]           tmr_q, tmr_d;
  logic [7:0]           bit_cnt_q, bit_cnt_d;
  logic [127:0]         shift_q, shift_d;
  logic                 sck_q, sck_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic signed [15:0]   quat_w_q, quat_w_d;
  logic signed [15:0]   quat_x_q, quat_x_d;
  logic signed [15:0]   quat_y_q, quat_y_d;
  logic signed [15:0]   quat_z_q, quat_z_d;
  logic signed [15:0]   gyro_x_q, gyro_x_d;
  logic signed [15:0]   gyro_y_q, gyro_y_d;
  logic signed [15:0]   gyro_z_q, gyro_z_d;
  logic                 quat_valid_q, quat_valid_d;
  logic                 gyro_valid_q, gyro_valid_d;
  logic                 pkt_valid_q, pkt_valid_d;
  logic                 hdr_err_q, hdr_err_d;
  logic [15:0]          good_count_q, good_count_d;

  logic                 tmr_done;
  logic                 hdr_ok;

  assign tmr_done = (tmr_q == 8'd0);
  assign hdr_ok   = (shift_q[127:120] == HEADER);

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sck_d        = sck_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    quat_w_d     = quat_w_q;
    quat_x_d     = quat_x_q;
    quat_y_d     = quat_y_q;
    quat_z_d     = quat_z_q;
    gyro_x_d     = gyro_x_q;
    gyro_y_d     = gyro_y_q;
    gyro_z_d     = gyro_z_q;
    quat_valid_d = quat_valid_q;
    gyro_valid_d = gyro_valid_q;
    pkt_valid_d  = 1'b0;
    hdr_err_d    = 1'b0;
    good_count_d = good_count_q;

    unique case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
        if (start) begin
          state_d   = SETUP;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 8'd0;
          tmr_d     = SETUP_LD;
        end
      end

      SETUP: begin
        if (tmr_done) begin
          state_d = SCK_LOW;
          tmr_d   = DIV_LOAD;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end

      // sdi is captured on the same edge that raises sck
      SCK_LOW: begin
        if (tmr_done) begin
          state_d   = SCK_HIGH;
          sck_d     = 1'b1;
          shift_d   = {shift_q[126:0], sdi};
          bit_cnt_d = bit_cnt_q + 8'd1;
          tmr_d     = DIV_LOAD;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end

      SCK_HIGH: begin
        if (tmr_done) begin
          sck_d = 1'b0;
          if (bit_cnt_q == PKT_BITS) begin
            state_d = HOLD;
            tmr_d   = HOLD_LD;
          end else begin
            state_d = SCK_LOW;
            tmr_d   = DIV_LOAD;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end

      HOLD: begin
        if (tmr_done) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          if (hdr_ok) begin
            quat_w_d     = shift_q[119:104];
            quat_x_d     = shift_q[103:88];
            quat_y_d     = shift_q[87:72];
            quat_z_d     = shift_q[71:56];
            gyro_x_d     = shift_q[55:40];
            gyro_y_d     = shift_q[39:24];
            gyro_z_d     = shift_q[23:8];
            quat_valid_d = shift_q[0];
            gyro_valid_d = shift_q[1];
            pkt_valid_d  = 1'b1;
            good_count_d = good_count_q + 16'd1;
          end else begin
            hdr_err_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= 8'd0;
      bit_cnt_q    <= 8'd0;
      shift_q      <= '0;
      sck_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      quat_w_q     <= '0;
      quat_x_q     <= '0;
      quat_y_q     <= '0;
      quat_z_q     <= '0;
      gyro_x_q     <= '0;
      gyro_y_q     <= '0;
      gyro_z_q     <= '0;
      quat_valid_q <= 1'b0;
      gyro_valid_q <= 1'b0;
      pkt_valid_q  <= 1'b0;
      hdr_err_q    <= 1'b0;
      good_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sck_q        <= sck_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      quat_w_q     <= quat_w_d;
      quat_x_q     <= quat_x_d;
      quat_y_q     <= quat_y_d;
      quat_z_q     <= quat_z_d;
      gyro_x_q     <= gyro_x_d;
      gyro_y_q     <= gyro_y_d;
      gyro_z_q     <= gyro_z_d;
      quat_valid_q <= quat_valid_d;
      gyro_valid_q <= gyro_valid_d;
      pkt_valid_q  <= pkt_valid_d;
      hdr_err_q    <= hdr_err_d;
      good_count_q <= good_count_d;
    end
  end

  assign busy       = busy_q;
  assign cs_n       = cs_n_q;
  assign sck        = sck_q;
  assign sdo        = 1'b0;
  assign quat_w     = quat_w_q;
  assign quat_x     = quat_x_q;
  assign quat_y     = quat_y_q;
  assign quat_z     = quat_z_q;
  assign gyro_x     = gyro_x_q;
  assign gyro_y     = gyro_y_q;
  assign gyro_z     = gyro_z_q;
  assign quat_valid = quat_valid_q;
  assign gyro_valid = gyro_valid_q;
  assign pkt_valid  = pkt_valid_q;
  assign hdr_err    = hdr_err_q;
  assign good_count = good_count_q;

endmodule

// File: tb/tb_spi_packet_master_rx.sv
// Bench for spi_packet_master_rx: a byte-level slave model feeds packets and
// expected fields/timing are derived from the packet bytes and timing rules.
module tb_spi_packet_master_rx;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int XFER     = CS_SETUP + 256 * CLK_DIV + CS_HOLD;
  localparam int BUDGET   = XFER + 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sdi;
  logic busy, cs_n, sck, sdo;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;
  logic quat_valid, gyro_valid, pkt_valid, hdr_err;
  logic [15:0] good_count;

  spi_packet_master_rx #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .cs_n(cs_n), .sck(sck),
    .sdo(sdo), .sdi(sdi), .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y),
    .quat_z(quat_z), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .quat_valid(quat_valid), .gyro_valid(gyro_valid), .pkt_valid(pkt_valid),
    .hdr_err(hdr_err), .good_count(good_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  wire [113:0] dut_fields = {quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
                             quat_valid, gyro_valid};

  // Slave: presents the MSB of the packet while CS is low and advances one bit
  // after each observed SCK fall.
  logic [127:0] slave_pkt = '0;
  int           slave_idx = 0;
  logic         sck_prev_s = 1'b0;
  always @(negedge clk) begin
    sck_prev_s <= sck;
    if (cs_n) slave_idx <= 0;
    else if (sck_prev_s && !sck) slave_idx <= slave_idx + 1;
  end
  assign sdi = (slave_idx < 128) ? slave_pkt[127 - slave_idx] : 1'b0;

  // SCK monitor: total toggles and phases that are not CLK_DIV cycles long.
  logic sck_m = 1'b0;
  int   run_len = 0;
  bit   phase_on = 1'b0;
  int   toggles = 0;
  int   phase_bad = 0;
  always @(negedge clk) begin
    sck_m <= sck;
    if (sck !== sck_m) begin
      toggles <= toggles + 1;
      if (phase_on && run_len != CLK_DIV) phase_bad <= phase_bad + 1;
      phase_on <= 1'b1;
      run_len  <= 1;
    end else begin
      run_len <= run_len + 1;
    end
    if (cs_n) phase_on <= 1'b0;
  end

  // Reference model state
  logic [113:0] exp_fields = '0;
  logic [15:0]  exp_count  = '0;

  typedef logic [7:0] pkt_t [16];

  typedef struct {
    int t0;
    int te;
    bit valid;
    bit err;
    bit busy0;
    bit csn0;
    bit busy_te;
    bit csn_te;
    bit stb_after;
    bit moved;
  } xfer_t;

  task automatic rand_pkt(output pkt_t b, input logic [7:0] hdr);
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
    b[0] = hdr;
  endtask

  task automatic load_slave(input pkt_t b);
    for (int i = 0; i < 16; i++) slave_pkt[127 - 8 * i -: 8] = b[i];
  endtask

  task automatic model_apply(input pkt_t b);
    if (b[0] == 8'hAA) begin
      exp_fields = {b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8], b[9], b[10],
                    b[11], b[12], b[13], b[14], b[15][0], b[15][1]};
      exp_count  = exp_count + 16'd1;
    end
  endtask

  // Issues one start pulse and follows the transfer to its strobe.
  task automatic run_transfer(input int extra_at, output xfer_t r);
    logic [129:0] snap;
    r = '{default: 0};
    r.te = -1;
    snap = {dut_fields, good_count};
    @(negedge clk);
    start = 1'b1;
    r.t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    r.busy0 = busy;
    r.csn0  = cs_n;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      start = (extra_at > 0 && cyc == r.t0 + extra_at - 1);
      if (pkt_valid || hdr_err) begin
        r.te      = cyc;
        r.valid   = pkt_valid;
        r.err     = hdr_err;
        r.busy_te = busy;
        r.csn_te  = cs_n;
        break;
      end
      if ({dut_fields, good_count} !== snap) r.moved = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    r.stb_after = pkt_valid | hdr_err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || sdo !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: cs_n=%b sck=%b busy=%b sdo=%b required 1 0 0 0", cs_n, sck, busy, sdo);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pkt_valid !== 1'b0 || hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: pkt_valid=%b hdr_err=%b required 0 0", pkt_valid, hdr_err);
    end
    checks++;
    if (dut_fields !== 114'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h required 0", dut_fields);
    end
    checks++;
    if (good_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %h required 0", good_count);
    end
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cs_n=%b busy=%b required 1 0", cs_n, busy);
    end
  endtask

  task automatic test_good_fixed;
    pkt_t  b;
    xfer_t r;
    b = '{8'hAA, 8'h40, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h00,
          8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h03};
    load_slave(b);
    model_apply(b);
    run_transfer(0, r);
    checks++;
    if (r.busy0 !== 1'b1 || r.csn0 !== 1'b0) begin
      errors++;
      $display("FAIL fixed_start: busy=%b cs_n=%b required 1 0", r.busy0, r.csn0);
    end
    checks++;
    if (r.te != r.t0 + XFER) begin
      errors++;
      $display("FAIL fixed_te: got %0d required %0d", r.te, r.t0 + XFER);
    end
    checks++;
    if (r.valid !== 1'b1 || r.err !== 1'b0 || r.stb_after !== 1'b0) begin
      errors++;
      $display("FAIL fixed_strobe: valid=%b err=%b after=%b required 1 0 0", r.valid, r.err, r.stb_after);
    end
    checks++;
    if (r.csn_te !== 1'b1 || r.busy_te !== 1'b0) begin
      errors++;
      $display("FAIL fixed_end: cs_n=%b busy=%b required 1 0", r.csn_te, r.busy_te);
    end
    checks++;
    if (r.moved) begin
      errors++;
      $display("FAIL fixed_stable: outputs changed before TE, got 1 required 0");
    end
    checks++;
    if (dut_fields !== exp_fields) begin
      errors++;
      $display("FAIL fixed_fields: got %h required %h", dut_fields, exp_fields);
    end
    checks++;
    if (quat_y !== -1 || quat_z !== -32768) begin
      errors++;
      $display("FAIL fixed_signed: quat_y=%0d quat_z=%0d required -1 -32768", quat_y, quat_z);
    end
    checks++;
    if (good_count !== 16'd1) begin
      errors++;
      $display("FAIL fixed_count: got %0d required 1", good_count);
    end
  endtask

  task automatic test_hdr_err;
    pkt_t  b;
    xfer_t r;
    rand_pkt(b, 8'h55);
    load_slave(b);
    model_apply(b);
    run_transfer(0, r);
    checks++;
    if (r.te != r.t0 + XFER) begin
      errors++;
      $display("FAIL hdr_te: got %0d required %0d", r.te, r.t0 + XFER);
    end
    checks++;
    if (r.err !== 1'b1 || r.valid !== 1'b0 || r.stb_after !== 1'b0) begin
      errors++;
      $display("FAIL hdr_strobe: err=%b valid=%b after=%b required 1 0 0", r.err, r.valid, r.stb_after);
    end
    checks++;
    if (dut_fields !== exp_fields || good_count !== exp_count) begin
      errors++;
      $display("FAIL hdr_retain: fields=%h count=%0d required %h %0d", dut_fields, good_count, exp_fields, exp_count);
    end
  endtask

  task automatic test_start_ignored;
    pkt_t  b;
    xfer_t r;
    int    active;
    rand_pkt(b, 8'hAA);
    load_slave(b);
    model_apply(b);
    run_transfer(100, r);
    checks++;
    if (r.te != r.t0 + XFER || r.valid !== 1'b1) begin
      errors++;
      $display("FAIL ignore_te: te=%0d valid=%b required %0d 1", r.te, r.valid, r.t0 + XFER);
    end
    checks++;
    if (dut_fields !== exp_fields || good_count !== exp_count) begin
      errors++;
      $display("FAIL ignore_fields: fields=%h count=%0d required %h %0d", dut_fields, good_count, exp_fields, exp_count);
    end
    active = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || !cs_n) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL ignore_no_second: active cycles %0d required 0", active);
    end
  endtask

  task automatic test_reset_mid;
    pkt_t  b;
    xfer_t r;
    int    t0;
    int    bit60;
    rand_pkt(b, 8'hAA);
    load_slave(b);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    bit60 = t0 + CS_SETUP + CLK_DIV + 2 * CLK_DIV * 60;
    for (int i = 0; i < BUDGET && cyc < bit60; i++) @(negedge clk);
    checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_active: cs_n=%b busy=%b required 0 1", cs_n, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fields = '0;
    exp_count  = '0;
    checks++;
    if (cs_n !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || pkt_valid !== 1'b0 || hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pins: cs_n=%b sck=%b busy=%b pv=%b he=%b required 1 0 0 0 0",
               cs_n, sck, busy, pkt_valid, hdr_err);
    end
    checks++;
    if (dut_fields !== 114'd0 || good_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_clear: fields=%h count=%0d required 0 0", dut_fields, good_count);
    end
    rand_pkt(b, 8'hAA);
    load_slave(b);
    model_apply(b);
    run_transfer(0, r);
    checks++;
    if (r.te != r.t0 + XFER || r.valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_next_te: te=%0d valid=%b required %0d 1", r.te, r.valid, r.t0 + XFER);
    end
    checks++;
    if (dut_fields !== exp_fields || good_count !== 16'd1) begin
      errors++;
      $display("FAIL midrst_next_fields: fields=%h count=%0d required %h 1", dut_fields, good_count, exp_fields);
    end
  endtask

  task automatic test_back_to_back;
    pkt_t pk [3];
    int   tog0, bad0, t0, te, exp_te;
    for (int p = 0; p < 3; p++) rand_pkt(pk[p], 8'hAA);
    load_slave(pk[0]);
    @(negedge clk);
    tog0 = toggles;
    bad0 = phase_bad;
    start = 1'b1;
    t0 = cyc + 1;
    exp_te = t0 + XFER;
    for (int p = 0; p < 3; p++) begin
      te = -1;
      for (int i = 0; i < BUDGET; i++) begin
        @(negedge clk);
        if (pkt_valid || hdr_err) begin
          te = cyc;
          break;
        end
      end
      model_apply(pk[p]);
      checks++;
      if (te != exp_te || pkt_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_te[%0d]: te=%0d valid=%b required %0d 1", p, te, pkt_valid, exp_te);
      end
      checks++;
      if (dut_fields !== exp_fields || good_count !== exp_count) begin
        errors++;
        $display("FAIL b2b_fields[%0d]: fields=%h count=%0d required %h %0d",
                 p, dut_fields, good_count, exp_fields, exp_count);
      end
      checks++;
      if (cs_n !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cs_high[%0d]: cs_n=%b required 1", p, cs_n);
      end
      if (p < 2) begin
        load_slave(pk[p + 1]);
        @(negedge clk);
        checks++;
        if (cs_n !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_retrigger[%0d]: cs_n=%b busy=%b required 0 1", p, cs_n, busy);
        end
        exp_te = exp_te + 1 + XFER;
      end else begin
        start = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (toggles - tog0 != 3 * 256) begin
      errors++;
      $display("FAIL b2b_toggles: got %0d required %0d", toggles - tog0, 3 * 256);
    end
    checks++;
    if (phase_bad != bad0) begin
      errors++;
      $display("FAIL b2b_phase_len: bad phases %0d required 0", phase_bad - bad0);
    end
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b cs_n=%b required 0 1", busy, cs_n);
    end
  endtask

  task automatic test_wrap;
    pkt_t  b;
    xfer_t r;
    @(negedge clk);
    force dut.good_count_q = 16'hFFFE;
    @(negedge clk);
    @(negedge clk);
    release dut.good_count_q;
    exp_count = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      rand_pkt(b, 8'hAA);
      load_slave(b);
      model_apply(b);
      run_transfer(0, r);
      checks++;
      if (r.valid !== 1'b1 || good_count !== exp_count || dut_fields !== exp_fields) begin
        errors++;
        $display("FAIL wrap[%0d]: valid=%b count=%h required 1 %h", k, r.valid, good_count, exp_count);
      end
    end
    checks++;
    if (good_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %h required 0000", good_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_fixed();
    test_hdr_err();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
